dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache placed between the MEM stage (EX_MEM outputs) and a multi-cycle backing data memory. MEM-stage hits complete in the same cycle. Misses assert a stall to the pipeline and run a line eviction and/or refill over a req/ack memory handshake. The MEM_WB register consumes `rdata_o` exactly as it consumed the old single-cycle data memory output.

## Interface

Parameters:
- `LINES`, 32: number of cache lines; power of two, ≥2.
- `ADDR_W`, 32: byte-address width.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `memread_i` in 1: MEM-stage load request.
- `memwrite_i` in 1: MEM-stage store request.
- `addr_i` in 32: byte address; bits [1:0] are ignored (word access only).
- `wdata_i` in 32: store data.
- `rdata_o` out 32: load data, valid when `memread_i && !stall_o`.
- `stall_o` out 1: freeze PC, IF_ID, ID_EX, EX_MEM; bubble MEM_WB.
- `mem_req_o` out 1: backing-memory request.
- `mem_we_o` out 1: 1 = line write-back, 0 = line fetch.
- `mem_addr_o` out 32: line-aligned address (bits [3:0] = 0).
- `mem_wdata_o` out 128: evicted line.
- `mem_rdata_i` in 128: fetched line, valid when `mem_ack_i`.
- `mem_ack_i` in 1: one-cycle completion pulse.

## Operation

- Line = 4 words. Address fields: word offset [3:2]; index [3+log2(LINES):4]; tag = remaining upper bits.
- Hit = `valid[index] && tag[index]==addr tag`.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, no request: `stall_o`=0.
- IDLE, read hit: `rdata_o` = selected word, combinational; `stall_o`=0.
- IDLE, write hit: the word is written at the clock edge and `dirty[index]`=1; `stall_o`=0.
- IDLE, miss: `stall_o`=1 combinationally. Latch `addr_i` into `miss_addr`. Go to WRITEBACK if the victim is valid and dirty, else to ALLOCATE.
- WRITEBACK: `mem_req_o`=1, `mem_we_o`=1, `mem_addr_o`={victim tag, index, 4'b0}, `mem_wdata_o`=victim line. On `mem_ack_i`: clear dirty and go to ALLOCATE.
- ALLOCATE: `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o`=line address of `miss_addr`. On `mem_ack_i`: write `mem_rdata_i` into the line, set valid=1, set tag, set dirty=0, go to IDLE.
- After the refill, the held request is re-evaluated in IDLE, hits, and completes normally; a store sets dirty at that point.
- `stall_o`=1 in every cycle the FSM is not in IDLE.
- `memread_i` and `memwrite_i` both high: treated as a write.
- `mem_ack_i` outside WRITEBACK/ALLOCATE: ignored.
- The pipeline holds `addr_i`, `wdata_i` and the request strobes stable while `stall_o`=1. The memory side uses only `miss_addr`.

## Timing

- Reset (synchronous): FSM = IDLE, all valid and dirty bits = 0.
- Reset values of outputs: `mem_req_o`=0, `mem_we_o`=0, `stall_o`=0 (no request pending), `mem_addr_o`=0, `mem_wdata_o`=0. `rdata_o` is don't-care with no valid line.
- Tag and data arrays are not reset.
- Hit latency: 0 cycles; no stall.
- Clean miss detected in cycle t:
  - ALLOCATE from cycle t+1.
  - Ack sampled in cycle t+1+L, where L ≥ 0 is memory wait.
  - IDLE hit in cycle t+2+L.
  - Total stall = L+2 cycles.
- A dirty miss adds Lw+1 cycles for the WRITEBACK phase (Lw = memory wait on the write-back).
- `mem_req_o` stays asserted with stable `mem_addr_o`/`mem_wdata_o` until the ack cycle inclusive. It is deasserted the cycle after the ack unless the next phase begins.
- Reset mid-transaction: IDLE next cycle, `mem_req_o`=0, all lines invalid. The outstanding memory transaction is abandoned and the memory model must tolerate it.
- Index wrap: addresses that differ only in tag map to the same line and evict each other.

## Structure

- Shared package `dcache_pkg`:
  - state enum {IDLE, WRITEBACK, ALLOCATE};
  - `LINE_W`=128, `OFFSET_W`=2;
  - index/tag width derivation from `LINES`;
  - field-extract functions `idx_of`, `tag_of`, `word_of`.
- Sub-module `dcache_array`: valid/dirty flop vectors, plus tag and data arrays.
  - One combinational read port addressed by index.
  - Write ports: word write (store hit), line write (refill), dirty clear.
- `dcache_ctrl` holds the FSM, `miss_addr`, the hit compare and the memory-port muxing.

## Test plan

- After reset, read 0x100 with L=3, line refilled with words {A,B,C,D} → `stall_o` high for 5 cycles, `mem_we_o`=0, `mem_addr_o`=0x100, then `rdata_o`=A. A following read of 0x10C returns D with no stall.
- Write 0xDEADBEEF to 0x104 (hit) → no stall. Read 0x104 → 0xDEADBEEF.
- Read 0x2104 (same index, different tag) → write-back of the 0x100 line carrying 0xDEADBEEF in word 1, then a fetch from 0x2100. Stall = Lw+1+L+2 cycles.
- Store miss at 0x300 → line allocated, word written after the refill, dirty=1. An evicting access later writes the line back to 0x300.
- Assert `rst_i` during ALLOCATE → next cycle `mem_req_o`=0 and `stall_o`=0. Re-reading 0x100 misses again.
- `mem_ack_i` pulsed while in IDLE, and simultaneous read+write strobes → the ack is ignored with no state change; the simultaneous access acts as a write.

Source files
------------

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, widths and address field helpers for the data cache
//
// Purpose: state encoding, line geometry and address decomposition used by
//          dcache_ctrl, dcache_array and the memory-side interface.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    localparam int LINE_W     = 128;
    localparam int OFFSET_W   = 2;
    localparam int BYTE_OFF_W = OFFSET_W + 2;

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int lines);
        return addr_w - BYTE_OFF_W - $clog2(lines);
    endfunction

    // Callers truncate the results to IDX_W / TAG_W.
    function automatic logic [31:0] idx_of(input logic [31:0] addr, input int lines);
        return (addr >> BYTE_OFF_W) & 32'(lines - 1);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] addr, input int lines);
        return addr >> (BYTE_OFF_W + $clog2(lines));
    endfunction

    function automatic logic [OFFSET_W-1:0] word_of(input logic [31:0] addr);
        return addr[3:2];
    endfunction

endpackage

// File: rtl/dcache_if.sv
// rtl/dcache_if.sv - line-wide req/ack bus between the data cache and backing memory
//
// Purpose: groups the backing-memory handshake.
// Ports (master = cache side):
//   mem_req   out  request active, held until the ack cycle inclusive
//   mem_we    out  1 = line write-back, 0 = line fetch
//   mem_addr  out  line-aligned byte address
//   mem_wdata out  evicted line
//   mem_rdata in   fetched line, valid with mem_ack
//   mem_ack   in   one-cycle completion pulse
interface dcache_if
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - valid/dirty/tag/data storage for the direct-mapped cache
//
// Purpose: one combinational read port and three write ports.
// Ports:
//   clk_i, rst_i           clock, sync active-high reset (clears valid/dirty only)
//   rd_idx_i               read index; rd_valid_o/rd_dirty_o/rd_tag_o/rd_line_o
//   ww_en_i/ww_idx_i/ww_word_i/ww_data_i   store-hit word write, sets dirty
//   lw_en_i/lw_idx_i/lw_tag_i/lw_data_i    refill line write, sets valid, clears dirty
//   dc_en_i/dc_idx_i       dirty clear after write-back
module dcache_array
    import dcache_pkg::*;
#(
    parameter int LINES = 32,
    parameter int TAG_W = 23,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [IDX_W-1:0]    rd_idx_i,
    output logic                rd_valid_o,
    output logic                rd_dirty_o,
    output logic [TAG_W-1:0]    rd_tag_o,
    output logic [LINE_W-1:0]   rd_line_o,
    input  logic                ww_en_i,
    input  logic [IDX_W-1:0]    ww_idx_i,
    input  logic [OFFSET_W-1:0] ww_word_i,
    input  logic [31:0]         ww_data_i,
    input  logic                lw_en_i,
    input  logic [IDX_W-1:0]    lw_idx_i,
    input  logic [TAG_W-1:0]    lw_tag_i,
    input  logic [LINE_W-1:0]   lw_data_i,
    input  logic                dc_en_i,
    input  logic [IDX_W-1:0]    dc_idx_i
);
    logic [LINES-1:0]  valid_q, valid_d;
    logic [LINES-1:0]  dirty_q, dirty_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (lw_en_i) begin
            valid_d[lw_idx_i] = 1'b1;
            dirty_d[lw_idx_i] = 1'b0;
        end
        if (ww_en_i) dirty_d[ww_idx_i] = 1'b1;
        if (dc_en_i) dirty_d[dc_idx_i] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data contents are meaningless while valid is clear, so no reset.
    always_ff @(posedge clk_i) begin
        if (lw_en_i) begin
            tag_q[lw_idx_i]  <= lw_tag_i;
            data_q[lw_idx_i] <= lw_data_i;
        end
        if (ww_en_i) data_q[ww_idx_i][{ww_word_i, 5'b0} +: 32] <= ww_data_i;
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_line_o  = data_q[rd_idx_i];
endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
//
// Purpose: serves MEM-stage loads/stores with zero-latency hits; misses stall
//          the pipeline while the line is written back and/or refilled.
// Ports:
//   clk_i, rst_i            clock, sync active-high reset
//   memread_i, memwrite_i   MEM-stage strobes (both high acts as a store)
//   addr_i, wdata_i         byte address (word access), store data
//   rdata_o                 load data, valid when memread_i && !stall_o
//   stall_o                 pipeline freeze
//   mem_if                  backing-memory req/ack bus (master side)
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              stall_o,
    dcache_if.master          mem_if
);
    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(ADDR_W, LINES);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;

    logic                req;
    logic [IDX_W-1:0]    req_idx, miss_idx, rd_idx;
    logic [TAG_W-1:0]    req_tag, rd_tag;
    logic [OFFSET_W-1:0] req_word;
    logic                rd_valid, rd_dirty, hit;
    logic [LINE_W-1:0]   rd_line;
    logic                ww_en, lw_en, dc_en;

    assign req      = memread_i | memwrite_i;
    assign req_idx  = IDX_W'(idx_of(32'(addr_i), LINES));
    assign req_tag  = TAG_W'(tag_of(32'(addr_i), LINES));
    assign req_word = word_of(32'(addr_i));
    assign miss_idx = IDX_W'(idx_of(32'(miss_addr_q), LINES));

    // Outside IDLE the array is looked up at the miss line, which exposes the
    // victim tag/data for the write-back.
    assign rd_idx = (state_q == IDLE) ? req_idx : miss_idx;
    assign hit    = rd_valid && (rd_tag == req_tag);

    dcache_array #(
        .LINES (LINES),
        .TAG_W (TAG_W),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_idx_i   (rd_idx),
        .rd_valid_o (rd_valid),
        .rd_dirty_o (rd_dirty),
        .rd_tag_o   (rd_tag),
        .rd_line_o  (rd_line),
        .ww_en_i    (ww_en),
        .ww_idx_i   (req_idx),
        .ww_word_i  (req_word),
        .ww_data_i  (wdata_i),
        .lw_en_i    (lw_en),
        .lw_idx_i   (miss_idx),
        .lw_tag_i   (TAG_W'(tag_of(32'(miss_addr_q), LINES))),
        .lw_data_i  (mem_if.mem_rdata),
        .dc_en_i    (dc_en),
        .dc_idx_i   (miss_idx)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        unique case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    miss_addr_d = addr_i;
                    state_d     = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: if (mem_if.mem_ack) state_d = ALLOCATE;
            ALLOCATE:  if (mem_if.mem_ack) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_o          = 1'b0;
        mem_if.mem_req   = 1'b0;
        mem_if.mem_we    = 1'b0;
        mem_if.mem_addr  = '0;
        mem_if.mem_wdata = '0;
        ww_en            = 1'b0;
        lw_en            = 1'b0;
        dc_en            = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall_o = req && !hit;
                ww_en   = memwrite_i && hit;
            end
            WRITEBACK: begin
                stall_o          = 1'b1;
                mem_if.mem_req   = 1'b1;
                mem_if.mem_we    = 1'b1;
                mem_if.mem_addr  = {rd_tag, miss_idx, 4'b0};
                mem_if.mem_wdata = rd_line;
                dc_en            = mem_if.mem_ack;
            end
            ALLOCATE: begin
                stall_o         = 1'b1;
                mem_if.mem_req  = 1'b1;
                mem_if.mem_addr = {miss_addr_q[ADDR_W-1:4], 4'b0};
                lw_en           = mem_if.mem_ack;
            end
            default: stall_o = 1'b0;
        endcase
    end

    assign rdata_o = rd_line[{req_word, 5'b0} +: 32];
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl against a word-level memory model
module tb_dcache_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memread = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        stall;

    int errors = 0;
    int checks = 0;

    dcache_if #(.ADDR_W(32)) mem_if ();

    dcache_ctrl #(.LINES(32), .ADDR_W(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .memread_i  (memread),
        .memwrite_i (memwrite),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .rdata_o    (rdata),
        .stall_o    (stall),
        .mem_if     (mem_if)
    );

    always #5 clk = ~clk;

    // Reference: backing memory (word map), coherent program view (word map),
    // and which line each index currently holds.
    bit [31:0] bmem [bit [31:0]];
    bit [31:0] cw   [bit [31:0]];
    bit        m_valid [32];
    bit        m_dirty [32];
    int        m_tag   [32];

    function automatic bit [31:0] bm_rd(input bit [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
    endfunction

    function automatic bit [31:0] coh(input bit [31:0] a);
        if (cw.exists(a)) return cw[a];
        return bm_rd(a);
    endfunction

    function automatic bit [127:0] bm_line(input bit [31:0] la);
        return {bm_rd(la + 12), bm_rd(la + 8), bm_rd(la + 4), bm_rd(la)};
    endfunction

    function automatic bit [127:0] coh_line(input bit [31:0] la);
        return {coh(la + 12), coh(la + 8), coh(la + 4), coh(la)};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 0;
        end
        cw.delete();
    endtask

    // Memory responder step for one stalled cycle; lat_* are wait cycles per phase.
    task automatic serve(input int lw, input int lf, inout int cnt,
                         input bit [31:0] exp_wb_addr, input bit [127:0] exp_wb_line,
                         input bit [31:0] exp_fill_addr);
        if (mem_if.mem_req === 1'b1) begin
            if (mem_if.mem_we === 1'b1) begin
                if (cnt >= lw) begin
                    check("wb_addr", mem_if.mem_addr, exp_wb_addr);
                    check("wb_data", mem_if.mem_wdata, exp_wb_line);
                    for (int w = 0; w < 4; w++)
                        bmem[mem_if.mem_addr + 32'(4 * w)] = mem_if.mem_wdata[32*w +: 32];
                    mem_if.mem_ack = 1'b1;
                    cnt = 0;
                end else cnt++;
            end else begin
                if (cnt >= lf) begin
                    check("fill_addr", mem_if.mem_addr, exp_fill_addr);
                    mem_if.mem_rdata = bm_line(mem_if.mem_addr);
                    mem_if.mem_ack   = 1'b1;
                    cnt = 0;
                end else cnt++;
            end
        end
    endtask

    task automatic access(input bit rd, input bit wr, input bit [31:0] a, input bit [31:0] d,
                          input int lw, input int lf);
        int        idx = int'((a >> 4) & 31);
        int        tg  = int'(a >> 9);
        int        exp_stall;
        int        stalls = 0;
        int        cnt = 0;
        bit [31:0] vla = {m_tag[idx][22:0], idx[4:0], 4'b0};
        bit [127:0] vline = coh_line(vla);
        bit        miss = !(m_valid[idx] && m_tag[idx] == tg);
        if (!miss)                              exp_stall = 0;
        else if (m_valid[idx] && m_dirty[idx])  exp_stall = lw + 1 + lf + 2;
        else                                    exp_stall = lf + 2;

        @(negedge clk);
        memread = rd; memwrite = wr; addr = a; wdata = d;
        #1;
        while (stall === 1'b1 && stalls < 200) begin
            stalls++;
            serve(lw, lf, cnt, vla, vline, a & ~32'hF);
            @(negedge clk);
            mem_if.mem_ack = 1'b0;
            #1;
        end
        check("stall_cycles", 128'(stalls), 128'(exp_stall));
        if (rd && !wr) check("rdata", rdata, coh(a & ~32'h3));

        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        if (miss) m_dirty[idx] = 1'b0;
        if (wr) begin
            m_dirty[idx]        = 1'b1;
            cw[a & ~32'h3]      = d;
        end
    endtask

    initial begin
        int cnt;
        bit seen;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = '0;
        model_reset();

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_stall",   stall, 1'b0);
        check("rst_req",     mem_if.mem_req, 1'b0);
        check("rst_we",      mem_if.mem_we, 1'b0);
        check("rst_addr",    mem_if.mem_addr, 32'h0);
        check("rst_wdata",   mem_if.mem_wdata, 128'h0);

        access(1, 0, 32'h100, 0, 0, 3);
        access(1, 0, 32'h10C, 0, 0, 0);
        access(0, 1, 32'h104, 32'hDEADBEEF, 0, 0);
        access(1, 0, 32'h104, 0, 0, 0);
        access(1, 0, 32'h2104, 0, 2, 1);
        access(0, 1, 32'h300, 32'h12345678, 0, 2);
        access(1, 0, 32'h300, 0, 0, 0);
        access(1, 0, 32'h2300, 0, 1, 0);
        access(1, 0, 32'h300, 0, 0, 1);

        for (int i = 0; i < 40; i++) begin
            bit [31:0] ra = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 4)
                          | ($urandom_range(0, 3) << 2);
            bit        wr = 1'($urandom_range(0, 1));
            bit        rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            access(rd, wr, ra, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        @(negedge clk);
        memread = 1'b1; memwrite = 1'b0; addr = 32'h0000_4500;
        #1;
        cnt = 0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (mem_if.mem_req === 1'b1 && mem_if.mem_we === 1'b0) begin
                seen = 1'b1;
            end else begin
                serve(0, 99, cnt, {m_tag[16][22:0], 5'd16, 4'b0},
                      coh_line({m_tag[16][22:0], 5'd16, 4'b0}), 32'h4500);
                @(negedge clk);
                mem_if.mem_ack = 1'b0;
                #1;
            end
        end
        check("alloc_reached", seen, 1'b1);
        rst = 1'b1; memread = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_req",   mem_if.mem_req, 1'b0);
        check("midrst_stall", stall, 1'b0);
        model_reset();

        access(1, 0, 32'h100, 0, 0, 1);

        @(negedge clk);
        memread = 1'b0; memwrite = 1'b0;
        mem_if.mem_ack = 1'b1; mem_if.mem_rdata = {4{32'hBAD0BAD0}};
        #1;
        check("idle_ack_stall", stall, 1'b0);
        check("idle_ack_req",   mem_if.mem_req, 1'b0);
        @(negedge clk);
        mem_if.mem_ack = 1'b0;
        access(1, 0, 32'h100, 0, 0, 0);
        access(1, 1, 32'h108, 32'hA5A5_0F0F, 0, 0);
        access(1, 0, 32'h108, 0, 0, 0);
        access(1, 1, 32'h2108, 32'h0BAD_CAFE, 2, 2);
        access(1, 0, 32'h108, 0, 1, 1);

        @(negedge clk);
        memread = 1'b0; memwrite = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
